// File: rtl/mdp3_book_parser.sv
// mdp3_book_parser: streaming CME MDP 3.0 incremental book-refresh decoder.
// Takes one SBE message per frame on a little-endian byte bus and emits one
// record per repeating-group entry. Each message ends with a msg_done/msg_status pulse.
module mdp3_book_parser #(
  parameter int BUS_BYTES   = 8,
  parameter int MAX_ENTRIES = 16,
  parameter int TEMPLATE_ID = 46,
  parameter int QTY_W       = 16,
  parameter int ORD_W       = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [8*BUS_BYTES-1:0]     in_data,
  input  logic                       in_last,
  input  logic [$clog2(BUS_BYTES):0] in_nbytes,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [63:0]                out_price,
  output logic [QTY_W-1:0]           out_qty,
  output logic [ORD_W-1:0]           out_orders,
  output logic [31:0]                out_secid,
  output logic [1:0]                 out_action,
  output logic [1:0]                 out_entry_type,
  output logic                       out_last,
  output logic                       msg_done,
  output logic [1:0]                 msg_status
);

  localparam int          NB_W    = $clog2(BUS_BYTES) + 1;
  localparam logic [7:0]  MAX_E   = 8'(MAX_ENTRIES);
  localparam logic [15:0] TID     = 16'(TEMPLATE_ID);
  localparam logic [15:0] MIN_GBL = 16'd27;

  typedef enum logic [1:0] {S_HDR, S_ENTRY, S_SKIP} state_t;

  state_t             state_q, state_d;
  logic [31:0]        base_q, base_d, start_q, start_d;
  logic [7:0]         cnt_q, cnt_d, num_q, num_d, limit;
  logic [15:0]        tid_q, tid_d, gbl_q, gbl_d;
  logic [1:0]         skip_st_q, skip_st_d;
  logic [63:0]        price_q, price_d;
  logic [31:0]        size_q, size_d, secid_q, secid_d, orders_q, orders_d;
  logic [7:0]         action_q, action_d, etype_q, etype_d;
  logic               out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [63:0]        out_price_q, out_price_d;
  logic [QTY_W-1:0]   out_qty_q, out_qty_d;
  logic [ORD_W-1:0]   out_orders_q, out_orders_d;
  logic [31:0]        out_secid_q, out_secid_d;
  logic [1:0]         out_action_q, out_action_d, out_etype_q, out_etype_d;
  logic               msg_done_q, msg_done_d;
  logic [1:0]         msg_status_q, msg_status_d;

  logic [31:0]        abs_off, ent_rel, cur_start;
  logic               ent_en, completed, final_ent, hdr_done, rec_ok;
  logic [7:0]         lane_b;
  logic [63:0]        snap_price;
  logic [31:0]        snap_size, snap_secid, snap_orders;
  logic [7:0]         snap_action, snap_etype;
  logic [1:0]         snap_code;

  assign limit    = (num_q > MAX_E) ? MAX_E : num_q;
  assign in_ready = !(out_valid_q && !out_ready);

  function automatic logic [QTY_W-1:0] sat_qty(input logic [31:0] v);
    if (({32'd0, v} >> QTY_W) != 64'd0) return '1;
    return v[QTY_W-1:0];
  endfunction

  function automatic logic [ORD_W-1:0] sat_ord(input logic [31:0] v);
    if (({32'd0, v} >> ORD_W) != 64'd0) return '1;
    return v[ORD_W-1:0];
  endfunction

  // Map the ASCII entry type onto its 2-bit code and flag unknown types
  always_comb begin
    snap_code = 2'd0;
    rec_ok    = 1'b1;
    case (snap_etype)
      8'h30:   snap_code = 2'd0;
      8'h31:   snap_code = 2'd1;
      8'h45:   snap_code = 2'd2;
      8'h46:   snap_code = 2'd3;
      default: rec_ok = 1'b0;
    endcase
    if (snap_action > 8'd2) rec_ok = 1'b0;
  end

  // Lane-wise field capture, header decision, entry completion and record push
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    start_d      = start_q;
    cnt_d        = cnt_q;
    tid_d        = tid_q;
    gbl_d        = gbl_q;
    num_d        = num_q;
    skip_st_d    = skip_st_q;
    price_d      = price_q;
    size_d       = size_q;
    secid_d      = secid_q;
    orders_d     = orders_q;
    action_d     = action_q;
    etype_d      = etype_q;
    out_valid_d  = out_valid_q && !out_ready;
    out_last_d   = out_last_q;
    out_price_d  = out_price_q;
    out_qty_d    = out_qty_q;
    out_orders_d = out_orders_q;
    out_secid_d  = out_secid_q;
    out_action_d = out_action_q;
    out_etype_d  = out_etype_q;
    msg_done_d   = 1'b0;
    msg_status_d = msg_status_q;
    abs_off      = 32'd0;
    ent_rel      = 32'd0;
    ent_en       = 1'b0;
    lane_b       = 8'd0;
    cur_start    = start_q;
    completed    = 1'b0;
    final_ent    = 1'b0;
    hdr_done     = 1'b0;
    snap_price   = 64'd0;
    snap_size    = 32'd0;
    snap_secid   = 32'd0;
    snap_orders  = 32'd0;
    snap_action  = 8'd0;
    snap_etype   = 8'h30;
    if (in_valid && in_ready) begin
      for (int k = 0; k < BUS_BYTES; k++) begin
        abs_off = base_q + 32'(k);
        lane_b  = in_data[8*k +: 8];
        ent_en  = 1'b0;
        ent_rel = 32'd0;
        if (!in_last || (NB_W'(k) < in_nbytes)) begin
          if (state_q == S_HDR) begin
            case (abs_off)
              32'd4:   tid_d[7:0]  = lane_b;
              32'd5:   tid_d[15:8] = lane_b;
              32'd21:  gbl_d[7:0]  = lane_b;
              32'd22:  gbl_d[15:8] = lane_b;
              32'd23:  begin num_d = lane_b; hdr_done = 1'b1; end
              default: ;
            endcase
            if (abs_off >= 32'd24) begin
              ent_en  = 1'b1;
              ent_rel = abs_off - 32'd24;
            end
          end else if (state_q == S_ENTRY && !final_ent) begin
            ent_en  = 1'b1;
            ent_rel = abs_off - cur_start;
          end
        end
        if (ent_en) begin
          if (ent_rel < 32'd8)       price_d[{ent_rel[2:0], 3'b000} +: 8] = lane_b;
          else if (ent_rel < 32'd12) size_d[{ent_rel[1:0], 3'b000} +: 8]  = lane_b;
          else if (ent_rel < 32'd16) secid_d[{ent_rel[1:0], 3'b000} +: 8] = lane_b;
          else if (ent_rel >= 32'd20 && ent_rel < 32'd24)
            orders_d[{ent_rel[1:0], 3'b000} +: 8] = lane_b;
          else if (ent_rel == 32'd25) action_d = lane_b;
          else if (ent_rel == 32'd26) etype_d  = lane_b;
        end
        if (ent_en && state_q == S_ENTRY && ent_rel == {16'd0, gbl_q - 16'd1}) begin
          completed   = 1'b1;
          snap_price  = price_d;
          snap_size   = size_d;
          snap_secid  = secid_d;
          snap_orders = orders_d;
          snap_action = action_d;
          snap_etype  = etype_d;
          if (cnt_q + 8'd1 == limit) final_ent = 1'b1;
          cur_start = cur_start + {16'd0, gbl_q};
        end
      end
      base_d = base_q + 32'(BUS_BYTES);
      if (state_q == S_HDR && hdr_done) begin
        start_d = 32'd24;
        cnt_d   = 8'd0;
        if (tid_d != TID) begin
          state_d = S_SKIP; skip_st_d = 2'd1;
        end else if (gbl_d < MIN_GBL) begin
          state_d = S_SKIP; skip_st_d = 2'd2;
        end else if (num_d == 8'd0) begin
          state_d = S_SKIP; skip_st_d = 2'd0;
        end else begin
          state_d = S_ENTRY;
        end
      end
      if (state_q == S_ENTRY && completed) begin
        start_d = cur_start;
        cnt_d   = cnt_q + 8'd1;
        if (final_ent) begin
          state_d   = S_SKIP;
          skip_st_d = (num_q > MAX_E) ? 2'd3 : 2'd0;
        end
      end
      if (completed && rec_ok) begin
        out_valid_d  = 1'b1;
        out_last_d   = final_ent;
        out_price_d  = snap_price;
        out_qty_d    = sat_qty(snap_size);
        out_orders_d = sat_ord(snap_orders);
        out_secid_d  = snap_secid;
        out_action_d = snap_action[1:0];
        out_etype_d  = snap_code;
      end
      if (in_last) begin
        msg_done_d   = 1'b1;
        msg_status_d = (state_d == S_SKIP) ? skip_st_d : 2'd2;
        state_d      = S_HDR;
        base_d       = 32'd0;
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_HDR;
      base_q       <= 32'd0;
      start_q      <= 32'd0;
      cnt_q        <= 8'd0;
      tid_q        <= 16'd0;
      gbl_q        <= 16'd0;
      num_q        <= 8'd0;
      skip_st_q    <= 2'd0;
      price_q      <= 64'd0;
      size_q       <= 32'd0;
      secid_q      <= 32'd0;
      orders_q     <= 32'd0;
      action_q     <= 8'd0;
      etype_q      <= 8'd0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_price_q  <= 64'd0;
      out_qty_q    <= '0;
      out_orders_q <= '0;
      out_secid_q  <= 32'd0;
      out_action_q <= 2'd0;
      out_etype_q  <= 2'd0;
      msg_done_q   <= 1'b0;
      msg_status_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      start_q      <= start_d;
      cnt_q        <= cnt_d;
      tid_q        <= tid_d;
      gbl_q        <= gbl_d;
      num_q        <= num_d;
      skip_st_q    <= skip_st_d;
      price_q      <= price_d;
      size_q       <= size_d;
      secid_q      <= secid_d;
      orders_q     <= orders_d;
      action_q     <= action_d;
      etype_q      <= etype_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_price_q  <= out_price_d;
      out_qty_q    <= out_qty_d;
      out_orders_q <= out_orders_d;
      out_secid_q  <= out_secid_d;
      out_action_q <= out_action_d;
      out_etype_q  <= out_etype_d;
      msg_done_q   <= msg_done_d;
      msg_status_q <= msg_status_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_last       = out_last_q;
  assign out_price      = out_price_q;
  assign out_qty        = out_qty_q;
  assign out_orders     = out_orders_q;
  assign out_secid      = out_secid_q;
  assign out_action     = out_action_q;
  assign out_entry_type = out_etype_q;
  assign msg_done       = msg_done_q;
  assign msg_status     = msg_status_q;

endmodule

// File: tb/tb_mdp3_book_parser.sv
// tb_mdp3_book_parser: directed bench for the MDP3 book parser, with an
// 8-byte bus instance and a 16-byte bus instance sharing one clock and reset.
module tb_mdp3_book_parser;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   chk_cnt = 0;
  int   last_cyc = 0;
  int   done_cyc8 = -1;
  int   done_cyc16 = -1;
  int   nlast;
  bit   seen;

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter used to measure msg_done latency
  always @(posedge clk) cyc <= cyc + 1;

  logic        in_valid8, in_ready8, in_last8, out_valid8, out_ready8, out_last8, msg_done8;
  logic [63:0] in_data8, out_price8;
  logic [3:0]  in_nbytes8;
  logic [15:0] out_qty8;
  logic [7:0]  out_orders8;
  logic [31:0] out_secid8;
  logic [1:0]  out_action8, out_etype8, msg_status8;

  logic         in_valid16, in_ready16, in_last16, out_valid16, out_ready16, out_last16, msg_done16;
  logic [127:0] in_data16;
  logic [63:0]  out_price16;
  logic [4:0]   in_nbytes16;
  logic [15:0]  out_qty16;
  logic [7:0]   out_orders16;
  logic [31:0]  out_secid16;
  logic [1:0]   out_action16, out_etype16, msg_status16;

  mdp3_book_parser #(.BUS_BYTES(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_data(in_data8), .in_last(in_last8), .in_nbytes(in_nbytes8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_price(out_price8),
    .out_qty(out_qty8), .out_orders(out_orders8), .out_secid(out_secid8),
    .out_action(out_action8), .out_entry_type(out_etype8), .out_last(out_last8),
    .msg_done(msg_done8), .msg_status(msg_status8));

  mdp3_book_parser #(.BUS_BYTES(16)) dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16),
    .in_data(in_data16), .in_last(in_last16), .in_nbytes(in_nbytes16),
    .out_valid(out_valid16), .out_ready(out_ready16), .out_price(out_price16),
    .out_qty(out_qty16), .out_orders(out_orders16), .out_secid(out_secid16),
    .out_action(out_action16), .out_entry_type(out_etype16), .out_last(out_last16),
    .msg_done(msg_done16), .msg_status(msg_status16));

  typedef struct {
    logic [63:0] price;
    logic [15:0] qty;
    logic [7:0]  orders;
    logic [31:0] secid;
    logic [1:0]  action;
    logic [1:0]  etype;
    logic        last;
  } rec_t;

  rec_t       rec8[$];
  rec_t       rec16[$];
  logic [1:0] st8[$];
  logic [1:0] st16[$];
  logic [7:0] msg [0:1023];

  // Log every consumed record and every end-of-message status, sampled mid-cycle
  always @(negedge clk) begin
    if (out_valid8 && out_ready8)
      rec8.push_back('{out_price8, out_qty8, out_orders8, out_secid8, out_action8, out_etype8, out_last8});
    if (msg_done8) begin st8.push_back(msg_status8); done_cyc8 = cyc; end
    if (out_valid16 && out_ready16)
      rec16.push_back('{out_price16, out_qty16, out_orders16, out_secid16, out_action16, out_etype16, out_last16});
    if (msg_done16) begin st16.push_back(msg_status16); done_cyc16 = cyc; end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic checkRec(input string tag, input rec_t r, input logic [63:0] price,
                          input logic [15:0] qty, input logic [7:0] orders, input logic [31:0] secid,
                          input logic [1:0] action, input logic [1:0] etype, input logic last);
    checkOutput({tag, ".price"},  r.price,         price);
    checkOutput({tag, ".qty"},    64'(r.qty),      64'(qty));
    checkOutput({tag, ".orders"}, 64'(r.orders),   64'(orders));
    checkOutput({tag, ".secid"},  64'(r.secid),    64'(secid));
    checkOutput({tag, ".action"}, 64'(r.action),   64'(action));
    checkOutput({tag, ".etype"},  64'(r.etype),    64'(etype));
    checkOutput({tag, ".last"},   64'(r.last),     64'(last));
  endtask

  task automatic build_hdr(input int tid, input int gbl, input int n);
    for (int i = 0; i < 1024; i++) msg[i] = 8'h00;
    for (int i = 10; i < 18; i++) msg[i] = 8'hA5;
    msg[0]  = 8'h58;
    msg[2]  = 8'h0B;
    msg[4]  = tid[7:0];
    msg[5]  = tid[15:8];
    msg[21] = gbl[7:0];
    msg[22] = gbl[15:8];
    msg[23] = n[7:0];
  endtask

  task automatic put_entry(input int gbl, input int j, input logic [63:0] price, input logic [31:0] size,
                           input logic [31:0] secid, input logic [31:0] orders,
                           input logic [7:0] action, input logic [7:0] etype);
    int s;
    s = 24 + j * gbl;
    for (int k = 0; k < 8; k++) msg[s+k] = price[8*k +: 8];
    for (int k = 0; k < 4; k++) begin
      msg[s+8+k]  = size[8*k +: 8];
      msg[s+12+k] = secid[8*k +: 8];
      msg[s+16+k] = 8'hC3;
      msg[s+20+k] = orders[8*k +: 8];
    end
    msg[s+24] = 8'h7E;
    msg[s+25] = action;
    msg[s+26] = etype;
  endtask

  // Stream msg[0:len-1] into the selected instance, one word per accepted cycle
  task automatic applyStimulus(input bit wide, input int len, input bit with_last);
    logic [127:0] w;
    int  bb, nb;
    bit  is_last, accepted;
    bb = wide ? 16 : 8;
    for (int base = 0; base < len; base += bb) begin
      w  = '0;
      nb = (len - base < bb) ? len - base : bb;
      for (int k = 0; k < nb; k++) w[8*k +: 8] = msg[base+k];
      is_last = with_last && (base + bb >= len);
      if (wide) begin
        in_data16 = w; in_last16 = is_last; in_nbytes16 = 5'(nb); in_valid16 = 1'b1;
      end else begin
        in_data8 = w[63:0]; in_last8 = is_last; in_nbytes8 = 4'(nb); in_valid8 = 1'b1;
      end
      accepted = 1'b0;
      for (int t = 0; t < 200 && !accepted; t++) begin
        @(negedge clk);
        accepted = wide ? in_ready16 : in_ready8;
        @(posedge clk); #1;
      end
      if (!accepted) begin
        checkOutput("accept_timeout", 64'(accepted), 64'd1);
        break;
      end
      if (is_last) last_cyc = cyc;
    end
    in_valid8 = 1'b0; in_last8 = 1'b0; in_valid16 = 1'b0; in_last16 = 1'b0;
  endtask

  task automatic build_basic();
    build_hdr(46, 32, 2);
    put_entry(32, 0, 64'h3B5F47A0, 32'd12, 32'd123, 32'd2, 8'd0, 8'h30);
    put_entry(32, 1, 64'h1122334455667788, 32'd500, 32'd777, 32'd9, 8'd2, 8'h31);
  endtask

  initial begin
    reset = 1'b1;
    in_valid8 = 0; in_last8 = 0; in_data8 = '0; in_nbytes8 = '0; out_ready8 = 1'b1;
    in_valid16 = 0; in_last16 = 0; in_data16 = '0; in_nbytes16 = '0; out_ready16 = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    checkOutput("rst.out_valid",  64'(out_valid8),  64'd0);
    checkOutput("rst.msg_done",   64'(msg_done8),   64'd0);
    checkOutput("rst.msg_status", 64'(msg_status8), 64'd0);
    checkOutput("rst.in_ready",   64'(in_ready8),   64'd1);
    checkOutput("rst.out_price",  out_price8,       64'd0);
    checkOutput("rst.out_last",   64'(out_last8),   64'd0);
    @(posedge clk); #1;

    $display("[TB] basic two-entry message");
    build_basic();
    rec8.delete(); st8.delete();
    applyStimulus(0, 88, 1);
    repeat (3) @(posedge clk); #1;
    checkOutput("basic.nrec", 64'(rec8.size()), 64'd2);
    checkOutput("basic.ndone", 64'(st8.size()), 64'd1);
    checkOutput("basic.done_lat", 64'(done_cyc8), 64'(last_cyc));
    if (st8.size() > 0) checkOutput("basic.status", 64'(st8[0]), 64'd0);
    if (rec8.size() >= 2) begin
      checkRec("basic.r0", rec8[0], 64'h3B5F47A0, 16'd12, 8'd2, 32'd123, 2'd0, 2'd0, 1'b0);
      checkRec("basic.r1", rec8[1], 64'h1122334455667788, 16'd500, 8'd9, 32'd777, 2'd2, 2'd1, 1'b1);
    end

    $display("[TB] backpressure hold");
    rec8.delete(); st8.delete();
    out_ready8 = 1'b0;
    fork
      applyStimulus(0, 88, 1);
      begin
        seen = 1'b0;
        for (int t = 0; t < 300 && !seen; t++) begin @(negedge clk); seen = out_valid8; end
        checkOutput("hold.seen", 64'(seen), 64'd1);
        for (int t = 0; t < 5; t++) begin
          @(negedge clk);
          checkOutput("hold.in_ready",  64'(in_ready8),  64'd0);
          checkOutput("hold.out_valid", 64'(out_valid8), 64'd1);
          checkOutput("hold.price",     out_price8,      64'h3B5F47A0);
          checkOutput("hold.secid",     64'(out_secid8), 64'd123);
        end
        @(posedge clk); #1;
        out_ready8 = 1'b1;
      end
    join
    repeat (3) @(posedge clk); #1;
    checkOutput("hold.nrec", 64'(rec8.size()), 64'd2);
    if (rec8.size() >= 2) begin
      checkRec("hold.r0", rec8[0], 64'h3B5F47A0, 16'd12, 8'd2, 32'd123, 2'd0, 2'd0, 1'b0);
      checkOutput("hold.r1.last", 64'(rec8[1].last), 64'd1);
    end
    if (st8.size() > 0) checkOutput("hold.status", 64'(st8[0]), 64'd0);

    $display("[TB] template mismatch, short group, empty group");
    rec8.delete(); st8.delete();
    build_basic();
    msg[4] = 8'd32;
    applyStimulus(0, 88, 1);
    repeat (2) @(posedge clk); #1;
    checkOutput("tmpl.done_lat", 64'(done_cyc8), 64'(last_cyc));
    build_hdr(46, 26, 1);
    applyStimulus(0, 56, 1);
    build_hdr(46, 32, 0);
    applyStimulus(0, 32, 1);
    repeat (3) @(posedge clk); #1;
    checkOutput("misc.nrec", 64'(rec8.size()), 64'd0);
    checkOutput("misc.ndone", 64'(st8.size()), 64'd3);
    if (st8.size() >= 3) begin
      checkOutput("tmpl.status", 64'(st8[0]), 64'd1);
      checkOutput("gbl26.status", 64'(st8[1]), 64'd2);
      checkOutput("n0.status", 64'(st8[2]), 64'd0);
    end

    $display("[TB] entry overflow N=20");
    rec8.delete(); st8.delete();
    build_hdr(46, 27, 20);
    for (int j = 0; j < 20; j++)
      put_entry(27, j, 64'(j * 1000 + 1), 32'(j + 1), 32'(5000 + j), 32'(j), 8'(j % 3),
                (j % 4 == 0) ? 8'h30 : (j % 4 == 1) ? 8'h31 : (j % 4 == 2) ? 8'h45 : 8'h46);
    applyStimulus(0, 564, 1);
    repeat (3) @(posedge clk); #1;
    checkOutput("ovf.nrec", 64'(rec8.size()), 64'd16);
    nlast = 0;
    foreach (rec8[i]) if (rec8[i].last) nlast++;
    checkOutput("ovf.nlast", 64'(nlast), 64'd1);
    if (rec8.size() >= 16) begin
      checkRec("ovf.r1", rec8[1], 64'd1001, 16'd2, 8'd1, 32'd5001, 2'd1, 2'd1, 1'b0);
      checkRec("ovf.r15", rec8[15], 64'd15001, 16'd16, 8'd15, 32'd5015, 2'd0, 2'd3, 1'b1);
      checkOutput("ovf.r7.etype", 64'(rec8[7].etype), 64'd3);
      checkOutput("ovf.r14.action", 64'(rec8[14].action), 64'd2);
    end
    if (st8.size() > 0) checkOutput("ovf.status", 64'(st8[0]), 64'd3);

    $display("[TB] saturation and dropped entries");
    rec8.delete(); st8.delete();
    build_hdr(46, 32, 4);
    put_entry(32, 0, 64'd7, 32'd70000, 32'd1, 32'd300, 8'd1, 8'h31);
    put_entry(32, 1, 64'd8, 32'd65536, 32'd2, 32'd256, 8'd0, 8'h45);
    put_entry(32, 2, 64'd9, 32'd5, 32'd3, 32'd1, 8'd3, 8'h30);
    put_entry(32, 3, 64'd10, 32'd5, 32'd4, 32'd1, 8'd0, 8'h58);
    applyStimulus(0, 152, 1);
    repeat (3) @(posedge clk); #1;
    checkOutput("sat.nrec", 64'(rec8.size()), 64'd2);
    if (rec8.size() >= 2) begin
      checkRec("sat.r0", rec8[0], 64'd7, 16'hFFFF, 8'hFF, 32'd1, 2'd1, 2'd1, 1'b0);
      checkRec("sat.r1", rec8[1], 64'd8, 16'hFFFF, 8'hFF, 32'd2, 2'd0, 2'd2, 1'b0);
    end
    if (st8.size() > 0) checkOutput("sat.status", 64'(st8[0]), 64'd0);

    $display("[TB] 16-byte bus truncation and mid-frame reset");
    rec16.delete(); st16.delete();
    build_basic();
    applyStimulus(1, 40, 1);
    repeat (3) @(posedge clk); #1;
    checkOutput("trunc.nrec", 64'(rec16.size()), 64'd0);
    checkOutput("trunc.done_lat", 64'(done_cyc16), 64'(last_cyc));
    if (st16.size() > 0) checkOutput("trunc.status", 64'(st16[0]), 64'd2);
    rec16.delete(); st16.delete();
    applyStimulus(1, 32, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    applyStimulus(1, 88, 1);
    repeat (3) @(posedge clk); #1;
    checkOutput("rst16.nrec", 64'(rec16.size()), 64'd2);
    checkOutput("rst16.ndone", 64'(st16.size()), 64'd1);
    if (st16.size() > 0) checkOutput("rst16.status", 64'(st16[0]), 64'd0);
    if (rec16.size() >= 2) begin
      checkRec("rst16.r0", rec16[0], 64'h3B5F47A0, 16'd12, 8'd2, 32'd123, 2'd0, 2'd0, 1'b0);
      checkRec("rst16.r1", rec16[1], 64'h1122334455667788, 16'd500, 8'd9, 32'd777, 2'd2, 2'd1, 1'b1);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mdp3_book_parser.md
# mdp3_book_parser

Streaming CME MDP 3.0 parser for incremental book-refresh messages. It sits between the packet deframer and the order-book update logic. It accepts one SBE message per frame on a parametrised-width little-endian byte bus and emits one decoded record per repeating-group entry, with valid/ready backpressure. The block generalises the fixed 64-bit single-entry parser: bus width, entry limit and output field widths are parameters, there is template filtering, and every message ends with a status report.

## Interface
- BUS_BYTES, 8, input word width in bytes; legal values 8 or 16.
- MAX_ENTRIES, 16, maximum entries emitted per message; range 1..255.
- TEMPLATE_ID, 46, SBE templateId accepted for decoding.
- QTY_W, 16, out_qty width; range 1..32.
- ORD_W, 8, out_orders width; range 1..32.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid && in_ready.
- in_data  in  8*BUS_BYTES  message bytes; byte k is at in_data[8k+7:8k], and byte 0 is the earliest.
- in_last  in  1  final word of the message.
- in_nbytes  in  $clog2(BUS_BYTES)+1  number of valid bytes; sampled only when in_last is high, range 1..BUS_BYTES.
- out_valid  out  1  record valid.
- out_ready  in  1  record consumed when out_valid && out_ready.
- out_price  out  64  MDEntryPx mantissa.
- out_qty  out  QTY_W  MDEntrySize, saturated.
- out_orders  out  ORD_W  NumberOfOrders, saturated.
- out_secid  out  32  SecurityID.
- out_action  out  2  0 New, 1 Change, 2 Delete.
- out_entry_type  out  2  0 bid ('0'), 1 offer ('1'), 2 implied bid ('E'), 3 implied offer ('F').
- out_last  out  1  record is the final entry of a complete message.
- msg_done  out  1  one-cycle pulse at the end of each message.
- msg_status  out  2  valid with msg_done: 0 OK, 1 template mismatch, 2 malformed/truncated, 3 entry overflow.

## Operation
Message layout uses byte offsets from the first byte of the frame. All multi-byte fields are little-endian.
- Message header:
  - 0–1 MsgSize (ignored).
  - 2–3 BlockLength (ignored).
  - 4–5 TemplateId.
  - 10–17 TransactTime (ignored).
  - 21–22 group blockLength (GBL).
  - 23 numInGroup (N).
- Entry j starts at byte 24 + j*GBL. Fields relative to the entry start:
  - 0–7 price.
  - 8–11 size.
  - 12–15 secid.
  - 20–23 orders.
  - 25 UpdateAction.
  - 26 EntryType.
- Byte capture is lane-wise: each lane compares its absolute offset (word_base + lane) against the field offsets. This allows any field to straddle a word boundary.
- FSM states:
  - HDR collects bytes 0–23. After byte 23:
    - TemplateId != TEMPLATE_ID → SKIP, status 1.
    - GBL < 27 → SKIP, status 2.
    - N == 0 → SKIP, status 0.
    - Otherwise → ENTRY.
  - ENTRY captures fields. When an entry's last byte (offset GBL-1) is accepted, a record is pushed.
    - After min(N, MAX_ENTRIES) entries → SKIP. Status is 3 if N > MAX_ENTRIES, else 0.
  - SKIP discards words until in_last, then goes to HDR.
- Record push rules:
  - UpdateAction > 2, or an EntryType outside {'0','1','E','F'}, drops that entry silently. It still counts toward N and toward MAX_ENTRIES.
  - out_last=1 only on the last pushed record of a message whose final status is 0 or 3. If the final entry was dropped, no record carries out_last.
- Saturation: if size ≥ 2^QTY_W, out_qty is all ones; orders is treated the same way against ORD_W. Values are unsigned.
- Truncation: if in_last arrives in HDR or ENTRY before the required byte count (end = word_base + in_nbytes), status is 2. The partial entry is never emitted. Bytes beyond in_nbytes are ignored.
- Trailing bytes after the last entry are ignored.

## Timing
- Reset values: out_valid=0, msg_done=0, msg_status=0, out_last=0, all out_* data fields 0, in_ready=1, FSM=HDR, word_base=0.
- in_ready = !(out_valid && !out_ready). The input stalls whenever a held record is not being consumed.
- Record latency: out_valid rises the cycle after the word containing the entry's last byte is accepted. Record fields are stable while out_valid && !out_ready.
- Throughput: one word per cycle. At most one entry completes per word, because GBL ≥ 27 > BUS_BYTES.
- msg_done pulses the cycle after the in_last word is accepted. On the same cycle, word_base returns to 0 and the FSM is in HDR, so a back-to-back next message may be accepted on that cycle.
- A record pushed by the in_last word appears together with msg_done.
- Reset mid-message clears all state immediately. The next accepted word is treated as byte 0. No msg_done is produced for the aborted message.

## Test plan
- BUS_BYTES=8, one 88-byte message (template 46, GBL=32, N=2):
  - Entry 0: price 0x3B5F47A0, size 12, secid 123, orders 2, action 0, type '0'.
  - Entry 1: action 2, type '1'.
  - Required: two records {0x3B5F47A0, 12, 123, 2, 0, 0} then {…, 2, 1, last=1}, followed by msg_done with status 0.
- Same message with out_ready held low for 5 cycles after the first record → in_ready=0 and fields stable during the hold; no records lost or duplicated.
- TemplateId=32 → no records; msg_done with status 1 one cycle after in_last.
- N=20 with MAX_ENTRIES=16 → exactly 16 records, the 16th with out_last=1; status 3.
- Size=70000 with QTY_W=16, orders=300 with ORD_W=8 → out_qty=0xFFFF, out_orders=0xFF.
- BUS_BYTES=16, frame ending at byte 40 (entry 0 incomplete) → no record; status 2. Assert reset mid-frame, then a clean frame → normal decode.
